// File: rtl/reg_write_port.sv
// reg_write_port: 32-entry register file write port with a one-register-per-cycle clear sweep.
// Optional build macro REGWR_ZERO_X31_EN: register 31 has no storage and always reads zero.
module reg_write_port #(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_ack,
    output logic [DATA_W-1:0] regs [31:0]
);

    localparam int unsigned NREGS  = 32;
    localparam int unsigned ADDR_W = 5;
`ifdef REGWR_ZERO_X31_EN
    localparam int unsigned STORE_N = NREGS - 1;
`else
    localparam int unsigned STORE_N = NREGS;
`endif

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                busy_q;
    logic                wr_ack_q;
    logic                accept_c;
    logic [NREGS-1:0]    wr_sel_c;
    logic [NREGS-1:0]    clr_sel_c;
    logic [DATA_W-1:0]   regs_q [STORE_N];

    // A write is taken only when no sweep is running or being requested; clear wins ties.
    assign accept_c = wr_en & ~busy_q & ~clr_req;

    // One-hot write decode and one-hot clear-slot decode.
    always_comb begin
        wr_sel_c  = '0;
        clr_sel_c = '0;
        if (accept_c) begin
            wr_sel_c[wr_addr] = 1'b1;
        end
        if (state_q == ST_CLEAR) begin
            clr_sel_c[cnt_q] = 1'b1;
        end
    end

    // Register storage: clear slot or accepted write, otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < STORE_N; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < STORE_N; k++) begin
                if (clr_sel_c[k]) begin
                    regs_q[k] <= '0;
                end else if (wr_sel_c[k]) begin
                    regs_q[k] <= wr_data;
                end
            end
        end
    end

    // Clear-sweep FSM with registered busy and write acknowledge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            wr_ack_q <= 1'b0;
        end else begin
            wr_ack_q <= accept_c;
            case (state_q)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_CLEAR: begin
                    // Counter wrap to zero coincides with the return to idle.
                    cnt_q <= cnt_q + ADDR_W'(1);
                    if (cnt_q == ADDR_W'(NREGS - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Read side: stored registers, or constant zero for an unstored slot.
    for (genvar k = 0; k < int'(NREGS); k++) begin : g_out
        if (k < int'(STORE_N)) begin : g_store
            assign regs[k] = regs_q[k];
        end else begin : g_zero
            assign regs[k] = '0;
        end
    end

    assign busy   = busy_q;
    assign wr_ack = wr_ack_q;

endmodule

// File: tb/tb_reg_write_port.sv
// tb_reg_write_port: randomized scoreboard bench for reg_write_port.
// Honours REGWR_ZERO_X31_EN in its reference model when that macro is defined.
module tb_reg_write_port;

    localparam int unsigned DW = 64;

    typedef struct packed {
        logic                busy;
        logic                ack;
        logic [31:0][DW-1:0] r;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          clr_req;
    logic          busy;
    logic          wr_ack;
    logic [DW-1:0] dut_regs [31:0];

    int errors = 0;
    int checks = 0;

    exp_t sb [$];

    // Reference model: register contents plus remaining sweep length and position.
    logic [DW-1:0] m_regs [32];
    int            m_left;
    int            m_idx;
    logic          m_ack;

`ifdef REGWR_ZERO_X31_EN
    localparam bit ZERO31 = 1'b1;
`else
    localparam bit ZERO31 = 1'b0;
`endif

    reg_write_port #(.DATA_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .clr_req (clr_req),
        .busy    (busy),
        .wr_ack  (wr_ack),
        .regs    (dut_regs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_left = 0;
        m_idx  = 0;
        m_ack  = 1'b0;
    endtask

    // Advance the model by one clock edge for the given inputs and queue the expectation.
    task automatic step(input bit en, input logic [4:0] addr, input logic [DW-1:0] data, input bit clr);
        exp_t e;
        @(negedge clk);
        wr_en   = en;
        wr_addr = addr;
        wr_data = data;
        clr_req = clr;
        if (m_left > 0) begin
            m_regs[m_idx] = '0;
            m_idx  = m_idx + 1;
            m_left = m_left - 1;
            m_ack  = 1'b0;
        end else if (clr) begin
            m_left = 32;
            m_idx  = 0;
            m_ack  = 1'b0;
        end else if (en) begin
            if (!(ZERO31 && addr == 5'd31)) m_regs[addr] = data;
            m_ack = 1'b1;
        end else begin
            m_ack = 1'b0;
        end
        e.busy = (m_left > 0);
        e.ack  = m_ack;
        for (int i = 0; i < 32; i++) e.r[i] = m_regs[i];
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, '0, 1'b0);
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Direct check used around asynchronous reset, outside the cycle scoreboard.
    task automatic check_all_zero(input string tag);
        int bad;
        bad = -1;
        for (int i = 0; i < 32; i++) if (dut_regs[i] !== '0 && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s regs[%0d] got=%h want=0", tag, bad, dut_regs[bad]);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy got=%b want=0", tag, busy);
        end
        checks++;
        if (wr_ack !== 1'b0) begin
            errors++;
            $display("FAIL %s wr_ack got=%b want=0", tag, wr_ack);
        end
    endtask

    // Monitor: after every rising edge compare DUT outputs with the oldest expectation.
    initial begin
        exp_t e;
        int   bad;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (busy !== e.busy) begin
                    errors++;
                    $display("FAIL busy t=%0t got=%b want=%b", $time, busy, e.busy);
                end
                checks++;
                if (wr_ack !== e.ack) begin
                    errors++;
                    $display("FAIL wr_ack t=%0t got=%b want=%b", $time, wr_ack, e.ack);
                end
                bad = -1;
                for (int i = 0; i < 32; i++) if (dut_regs[i] !== e.r[i] && bad < 0) bad = i;
                checks++;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL regs t=%0t idx=%0d got=%h want=%h", $time, bad, dut_regs[bad], e.r[bad]);
                end
            end
        end
    end

    initial begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        clr_req = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset_state");
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        // Single write, then ack must drop.
        step(1'b1, 5'd5, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
        idle(2);

        // Fill every register with a distinct pattern.
        for (int k = 0; k < 32; k++) step(1'b1, 5'(k), DW'(k) * 64'h0101_0101_0101_0101, 1'b0);
        idle(1);

        // Clear sweep; at cnt=10 attempt a write to register 3, other cycles random writes.
        step(1'b0, 5'd0, '0, 1'b1);
        while (m_left > 0) begin
            if (m_idx == 10) step(1'b1, 5'd3, 64'h1, 1'b0);
            else step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), rnd64(), $urandom_range(0, 3) == 0);
        end
        idle(2);

        // Write vs clear in the same cycle, then clr_req held across the end of the sweep.
        step(1'b1, 5'd7, 64'h1234, 1'b0);
        step(1'b1, 5'd9, 64'h9999, 1'b0);
        step(1'b1, 5'd7, 64'h55, 1'b1);
        while (m_left > 0) step(1'b0, 5'd0, '0, 1'b1);
        step(1'b0, 5'd0, '0, 1'b1);
        step(1'b0, 5'd0, '0, 1'b0);
        while (m_left > 0) step(1'b1, 5'($urandom_range(0, 31)), rnd64(), 1'b0);

        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), rnd64(), $urandom_range(0, 39) == 0);
        end
        while (m_left > 0) idle(1);

        // Refill, start a sweep, and reset asynchronously while cnt is 15.
        for (int k = 0; k < 32; k++) step(1'b1, 5'(k), rnd64(), 1'b0);
        step(1'b0, 5'd0, '0, 1'b1);
        while (m_idx < 15) idle(1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check_all_zero("reset_mid_clear");
        model_reset();
        wr_en   = 1'b0;
        clr_req = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        step(1'b1, 5'd2, 64'hA5A5_0000_1111_2222, 1'b0);
        idle(2);
        for (int i = 0; i < 40; i++) step(1'b1, 5'($urandom_range(0, 31)), rnd64(), 1'b0);
        idle(1);

        // Drain: the monitor must have consumed every expectation.
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
